mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS32 pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its ALU result, store data, destination register and WB/M control bits.
- Performs load/store through a req/ready data-memory handshake.
- Stalls the pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register contents consumed by write-back.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mem_wb_reg.sv | 78 +++++++
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: control-bit positions, register-number width
// and the MEM-stage FSM encoding.
package mips_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int CTRL_W        = 5;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on load_en, squashes RegWrite/MemToReg on bubble,
// and keeps load data separately enabled so non-load instructions leave it untouched.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic                  bubble,
    input  logic                  misalign_in,
    input  logic                  mem_data_en,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     mem_data_in,
    input  logic [REG_ADDR_W-1:0] dst_reg_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     mem_data_out,
    output logic [REG_ADDR_W-1:0] dst_reg_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  misalign_out
);

    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     mem_data_q, mem_data_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  misalign_q, misalign_d;

    always_comb begin
        alu_d        = alu_q;
        mem_data_d   = mem_data_q;
        dst_d        = dst_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        // misalign is a pulse: it only lives for the cycle after the dropped op
        misalign_d   = misalign_in;
        if (load_en) begin
            alu_d        = alu_result_in;
            dst_d        = dst_reg_in;
            reg_write_d  = reg_write_in  & ~bubble;
            mem_to_reg_d = mem_to_reg_in & ~bubble;
        end
        if (mem_data_en) begin
            mem_data_d = mem_data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q        <= '0;
            mem_data_q   <= '0;
            dst_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            alu_q        <= alu_d;
            mem_data_q   <= mem_data_d;
            dst_q        <= dst_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            misalign_q   <= misalign_d;
        end
    end

    assign alu_result_out = alu_q;
    assign mem_data_out   = mem_data_q;
    assign dst_reg_out    = dst_q;
    assign reg_write_out  = reg_write_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign misalign_out   = misalign_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS32 MEM stage: single outstanding load/store over a req/ready data-memory port,
// stalling upstream stages until the access completes.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic [REG_ADDR_W-1:0] dst_reg_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     mem_data_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [REG_ADDR_W-1:0] dst_reg_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  misalign_out
);

    mem_state_e            state_q, state_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d;
    logic                  rw_q, rw_d;
    logic                  mtr_q, mtr_d;
    logic                  we_q, we_d;

    logic                  memop;
    logic                  aligned;
    logic                  stall_c;
    logic                  in_access;

    logic                  wb_load;
    logic                  wb_bubble;
    logic                  wb_mis;
    logic                  wb_md_en;
    logic [DATA_W-1:0]     wb_alu;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic                  wb_rw;
    logic                  wb_mtr;

    logic                  unused_ctrl;

    assign memop       = ctrl_in[CTRL_MEMREAD] | ctrl_in[CTRL_MEMWRITE];
    assign aligned     = is_word_aligned(alu_result_in[1:0]);
    assign unused_ctrl = ctrl_in[CTRL_W-1];

    always_comb begin
        state_d   = state_q;
        alu_d     = alu_q;
        wdata_d   = wdata_q;
        dst_d     = dst_q;
        rw_d      = rw_q;
        mtr_d     = mtr_q;
        we_d      = we_q;
        stall_c   = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_mis    = 1'b0;
        wb_md_en  = 1'b0;
        wb_alu    = alu_result_in;
        wb_dst    = dst_reg_in;
        wb_rw     = ctrl_in[CTRL_REGWRITE];
        wb_mtr    = ctrl_in[CTRL_MEMTOREG];
        unique case (state_q)
            IDLE: begin
                wb_load = 1'b1;
                if (memop) begin
                    wb_bubble = 1'b1;
                    if (!aligned) begin
                        wb_mis = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ACCESS;
                        alu_d   = alu_result_in;
                        wdata_d = store_data_in;
                        dst_d   = dst_reg_in;
                        rw_d    = ctrl_in[CTRL_REGWRITE];
                        mtr_d   = ctrl_in[CTRL_MEMTOREG];
                        // a read+write combination is treated as a write
                        we_d    = ctrl_in[CTRL_MEMWRITE];
                    end
                end
            end
            ACCESS: begin
                stall_c = ~dmem_ready;
                if (dmem_ready) begin
                    state_d  = IDLE;
                    wb_load  = 1'b1;
                    wb_alu   = alu_q;
                    wb_dst   = dst_q;
                    wb_rw    = rw_q;
                    wb_mtr   = mtr_q;
                    wb_md_en = ~we_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            alu_q   <= '0;
            wdata_q <= '0;
            dst_q   <= '0;
            rw_q    <= 1'b0;
            mtr_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            dst_q   <= dst_d;
            rw_q    <= rw_d;
            mtr_q   <= mtr_d;
            we_q    <= we_d;
        end
    end

    // stall is combinational from the inputs, so reset must mask it directly
    assign in_access  = (state_q == ACCESS);
    assign stall      = stall_c & ~reset;
    assign dmem_req   = in_access;
    assign dmem_we    = in_access & we_q;
    assign dmem_addr  = in_access ? {alu_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata = in_access ? wdata_q : '0;

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk            (clk),
        .reset          (reset),
        .load_en        (wb_load),
        .bubble         (wb_bubble),
        .misalign_in    (wb_mis),
        .mem_data_en    (wb_md_en),
        .alu_result_in  (wb_alu),
        .mem_data_in    (dmem_rdata),
        .dst_reg_in     (wb_dst),
        .reg_write_in   (wb_rw),
        .mem_to_reg_in  (wb_mtr),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .dst_reg_out    (dst_reg_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .misalign_out   (misalign_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, hand-written multi-cycle
// sequences and a randomized instruction stream against a transaction-level model.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  dst_reg_in;
    logic [4:0]  ctrl_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] mem_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  dst_reg_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        misalign_out;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] dut_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_md;

    mem_access_stage dut (
        .clk            (clk),
        .reset          (reset),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .dst_reg_in     (dst_reg_in),
        .ctrl_in        (ctrl_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .mem_data_out   (mem_data_out),
        .alu_result_out (alu_result_out),
        .dst_reg_out    (dst_reg_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .misalign_out   (misalign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] d, input logic [4:0] c);
        alu_result_in = a;
        store_data_in = s;
        dst_reg_in    = d;
        ctrl_in       = c;
    endtask

    task automatic check_wb(input string tag, input logic [31:0] e_alu, input logic [4:0] e_dst,
                            input logic e_rw, input logic e_mtr, input logic e_mis,
                            input logic [31:0] e_md);
        chk({tag, ".alu"},  alu_result_out, e_alu);
        chk({tag, ".dst"},  {27'd0, dst_reg_out}, {27'd0, e_dst});
        chk({tag, ".rw"},   {31'd0, reg_write_out}, {31'd0, e_rw});
        chk({tag, ".mtr"},  {31'd0, mem_to_reg_out}, {31'd0, e_mtr});
        chk({tag, ".mis"},  {31'd0, misalign_out}, {31'd0, e_mis});
        chk({tag, ".mdat"}, mem_data_out, e_md);
    endtask

    // Aligned memory op: IDLE cycle (stall, no request), then `delay` wait cycles and a
    // completing cycle, with the bench acting as the memory responder.
    task automatic mem_op(input logic [31:0] a, input logic [31:0] s, input logic [4:0] d,
                          input logic [4:0] c, input int delay, input string tag);
        logic        e_we;
        logic [31:0] e_addr;
        e_we   = c[1];
        e_addr = {a[31:2], 2'b00};
        drive(a, s, d, c);
        dmem_ready = 1'b0;
        #1;
        chk({tag, ".stall_idle"}, {31'd0, stall}, 32'd1);
        chk({tag, ".req_idle"},   {31'd0, dmem_req}, 32'd0);
        tick();
        chk({tag, ".bub_rw"},  {31'd0, reg_write_out}, 32'd0);
        chk({tag, ".bub_mtr"}, {31'd0, mem_to_reg_out}, 32'd0);
        drive($urandom, $urandom, 5'($urandom), 5'($urandom));
        for (int k = 0; k <= delay; k++) begin
            dmem_ready = (k == delay);
            dmem_rdata = $urandom;
            if (k == delay && dmem_req) begin
                if (dmem_we) dut_mem[dmem_addr] = dmem_wdata;
                dmem_rdata = dut_mem.exists(dmem_addr) ? dut_mem[dmem_addr] : init_word(dmem_addr);
            end
            #1;
            chk({tag, ".req"},   {31'd0, dmem_req}, 32'd1);
            chk({tag, ".we"},    {31'd0, dmem_we}, {31'd0, e_we});
            chk({tag, ".addr"},  dmem_addr, e_addr);
            if (e_we) chk({tag, ".wdata"}, dmem_wdata, s);
            chk({tag, ".stall"}, {31'd0, stall}, {31'd0, (k != delay)});
            tick();
        end
        dmem_ready = 1'b0;
        drive(32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
        logic [4:0]  d;
        logic [4:0]  c;
        logic [4:0]  e_dst;
        logic        e_rw;
        logic        e_mtr;
        logic        e_mis;
    } vec_t;

    vec_t tbl [6];

    initial begin
        reset = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        drive(32'd0, 32'd0, 5'd0, 5'd0);
        exp_md = 32'd0;

        tbl[0] = '{32'h0000_1234, 32'h0,         5'd5,  5'b00100, 5'd5,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0013, 32'h0,         5'd9,  5'b01101, 5'd9,  1'b0, 1'b0, 1'b1};
        tbl[2] = '{32'hFFFF_FFFF, 32'h1,         5'd31, 5'b01100, 5'd31, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'h0000_0022, 32'h5555_AAAA, 5'd3,  5'b00010, 5'd3,  1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0001, 32'h0,         5'd1,  5'b10111, 5'd1,  1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_0040, 32'h0,         5'd17, 5'b10000, 5'd17, 1'b0, 1'b0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check_wb("reset", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("reset.stall", {31'd0, stall}, 32'd0);
        chk("reset.req",   {31'd0, dmem_req}, 32'd0);
        reset = 1'b0;

        // single-cycle cases: ALU ops and dropped misaligned ops
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].c);
            #1;
            chk("tbl.stall", {31'd0, stall}, 32'd0);
            chk("tbl.req",   {31'd0, dmem_req}, 32'd0);
            chk("tbl.addr",  dmem_addr, 32'd0);
            tick();
            check_wb($sformatf("tbl%0d", i), tbl[i].a, tbl[i].e_dst, tbl[i].e_rw,
                     tbl[i].e_mtr, tbl[i].e_mis, exp_md);
            $display("vec %0d: ctrl=%05b addr=%08h rw=%0b mis=%0b", i, tbl[i].c, tbl[i].a,
                     reg_write_out, misalign_out);
        end

        // load, ready on first ACCESS cycle
        dut_mem[32'h10] = 32'hDEAD_BEEF;
        mem_op(32'h0000_0010, 32'h0, 5'd7, 5'b01101, 0, "load");
        check_wb("load", 32'h10, 5'd7, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        $display("load: addr=00000010 data=%08h", mem_data_out);

        // store with ready delayed three cycles
        mem_op(32'h0000_0020, 32'hCAFE_F00D, 5'd4, 5'b00010, 3, "store");
        check_wb("store", 32'h20, 5'd4, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("store.mem", dut_mem.exists(32'h20) ? dut_mem[32'h20] : 32'd0, 32'hCAFE_F00D);
        $display("store: addr=00000020 data=CAFEF00D");

        // back-to-back loads, second presented in the IDLE cycle after completion
        dut_mem[32'h4] = 32'h1111_0004;
        dut_mem[32'h8] = 32'h2222_0008;
        mem_op(32'h0000_0004, 32'h0, 5'd10, 5'b01101, 0, "b2b0");
        check_wb("b2b0", 32'h4, 5'd10, 1'b1, 1'b1, 1'b0, 32'h1111_0004);
        mem_op(32'h0000_0008, 32'h0, 5'd11, 5'b01101, 0, "b2b1");
        check_wb("b2b1", 32'h8, 5'd11, 1'b1, 1'b1, 1'b0, 32'h2222_0008);
        $display("b2b: loads 4 and 8 done, last=%08h", mem_data_out);

        // reset while waiting in ACCESS
        drive(32'h0000_0030, 32'h0, 5'd12, 5'b01101);
        dmem_ready = 1'b0;
        tick();
        #1;
        chk("rst.req_pre",   {31'd0, dmem_req}, 32'd1);
        chk("rst.stall_pre", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst.req",   {31'd0, dmem_req}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.addr",  dmem_addr, 32'd0);
        check_wb("rst", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        reset = 1'b0;
        drive(32'd0, 32'd0, 5'd0, 5'd0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        #1;
        chk("stray.req", {31'd0, dmem_req}, 32'd0);
        tick();
        check_wb("stray", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        dmem_ready = 1'b0;
        exp_md = 32'd0;
        $display("reset mid-access: outputs cleared");

        // randomized instruction stream against a transaction-level model
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, s;
            logic [4:0]  c, d;
            logic        memop, aligned, wr;
            int          kind, delay;
            kind = $urandom_range(0, 9);
            c = 5'($urandom);
            c[1:0] = (kind < 3) ? 2'b00 : (kind < 6) ? 2'b01 : (kind < 9) ? 2'b10 : 2'b11;
            d = 5'($urandom);
            s = $urandom;
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 6) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind < 3) a = $urandom;
            memop   = (c[0] | c[1]);
            aligned = (a % 4 == 0);
            wr      = c[1];
            if (memop && aligned) begin
                delay = $urandom_range(0, 3);
                mem_op(a, s, d, c, delay, "rnd");
                if (wr) ref_mem[a] = s;
                else exp_md = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                check_wb("rnd", a, d, c[2], c[3], 1'b0, exp_md);
            end else begin
                delay = 0;
                drive(a, s, d, c);
                #1;
                chk("rnd.stall", {31'd0, stall}, 32'd0);
                chk("rnd.req",   {31'd0, dmem_req}, 32'd0);
                tick();
                check_wb("rnd", a, d, c[2] & ~memop, c[3] & ~memop, memop, exp_md);
            end
            $display("txn %0d: ctrl=%05b addr=%08h delay=%0d mdat=%08h", i, c, a, delay,
                     mem_data_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
